// File: rtl/register_map.sv
// Architectural register map: committed data plus ROB tag/ready per register, two lookup ports.
// Optional macro REGMAP_RETIRE_BYPASS_EN forwards a same-cycle matching retire onto the lookup ports.
module register_map #(
  parameter  int DATA_WIDTH     = 32,
  parameter  int ROB_DEPTH      = 64,
  parameter  int REG_ADDR_WIDTH = 5,
  localparam int TAG_WIDTH      = $clog2(ROB_DEPTH)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      i_flush,
  input  logic                      i_dest_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_dest_wr_rdest,
  input  logic [TAG_WIDTH-1:0]      i_dest_wr_tag,
  input  logic [DATA_WIDTH-1:0]     i_dest_wr_data,
  input  logic                      i_tag_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_tag_wr_rdest,
  input  logic [TAG_WIDTH-1:0]      i_tag_wr_tag,
  input  logic [REG_ADDR_WIDTH-1:0] i_lookup_rsrc [0:1],
  output logic [DATA_WIDTH-1:0]     o_lookup_data [0:1],
  output logic [TAG_WIDTH-1:0]      o_lookup_tag  [0:1],
  output logic                      o_lookup_rdy  [0:1]
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] data_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] data_d [NUM_REGS];
  logic [TAG_WIDTH-1:0]  tag_q  [NUM_REGS];
  logic [TAG_WIDTH-1:0]  tag_d  [NUM_REGS];
  logic                  rdy_q  [NUM_REGS];
  logic                  rdy_d  [NUM_REGS];

  // Entry 0 is never written, so it keeps its reset value; lookups of r0 are forced anyway.
  // A rename outranks a retire's ready update, since the retiring producer is now stale.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      data_d[i] = data_q[i];
      tag_d[i]  = tag_q[i];
      rdy_d[i]  = rdy_q[i];
      if (i != 0) begin
        if (i_dest_wr_en && (i_dest_wr_rdest == REG_ADDR_WIDTH'(i))) begin
          data_d[i] = i_dest_wr_data;
        end
        if (i_flush) begin
          rdy_d[i] = 1'b1;
        end else if (i_tag_wr_en && (i_tag_wr_rdest == REG_ADDR_WIDTH'(i))) begin
          tag_d[i] = i_tag_wr_tag;
          rdy_d[i] = 1'b0;
        end else if (i_dest_wr_en && (i_dest_wr_rdest == REG_ADDR_WIDTH'(i)) &&
                     (tag_q[i] == i_dest_wr_tag)) begin
          rdy_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        rdy_q[i]  <= 1'b1;
      end
    end else begin
      data_q <= data_d;
      tag_q  <= tag_d;
      rdy_q  <= rdy_d;
    end
  end

  // Lookups read registered state only, so a same-cycle rename is invisible to its own sources.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      o_lookup_data[p] = data_q[i_lookup_rsrc[p]];
      o_lookup_tag[p]  = tag_q[i_lookup_rsrc[p]];
      o_lookup_rdy[p]  = rdy_q[i_lookup_rsrc[p]];
`ifdef REGMAP_RETIRE_BYPASS_EN
      if (i_dest_wr_en && (i_dest_wr_rdest == i_lookup_rsrc[p]) &&
          (tag_q[i_lookup_rsrc[p]] == i_dest_wr_tag)) begin
        o_lookup_data[p] = i_dest_wr_data;
        o_lookup_rdy[p]  = 1'b1;
      end
`else
`endif
      if (i_lookup_rsrc[p] == '0) begin
        o_lookup_data[p] = '0;
        o_lookup_tag[p]  = '0;
        o_lookup_rdy[p]  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_register_map.sv
// Directed vector table plus hand-written corner sequences for register_map (default parameters).
module tb_register_map;

  logic        clk;
  logic        n_rst;
  logic        i_flush;
  logic        i_dest_wr_en;
  logic [4:0]  i_dest_wr_rdest;
  logic [5:0]  i_dest_wr_tag;
  logic [31:0] i_dest_wr_data;
  logic        i_tag_wr_en;
  logic [4:0]  i_tag_wr_rdest;
  logic [5:0]  i_tag_wr_tag;
  logic [4:0]  i_lookup_rsrc [0:1];
  logic [31:0] o_lookup_data [0:1];
  logic [5:0]  o_lookup_tag  [0:1];
  logic        o_lookup_rdy  [0:1];

  int errors = 0;
  int checks = 0;

  register_map dut (
    .clk             (clk),
    .n_rst           (n_rst),
    .i_flush         (i_flush),
    .i_dest_wr_en    (i_dest_wr_en),
    .i_dest_wr_rdest (i_dest_wr_rdest),
    .i_dest_wr_tag   (i_dest_wr_tag),
    .i_dest_wr_data  (i_dest_wr_data),
    .i_tag_wr_en     (i_tag_wr_en),
    .i_tag_wr_rdest  (i_tag_wr_rdest),
    .i_tag_wr_tag    (i_tag_wr_tag),
    .i_lookup_rsrc   (i_lookup_rsrc),
    .o_lookup_data   (o_lookup_data),
    .o_lookup_tag    (o_lookup_tag),
    .o_lookup_rdy    (o_lookup_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        renEn;
    logic [4:0]  renRd;
    logic [5:0]  renTag;
    logic        retEn;
    logic [4:0]  retRd;
    logic [5:0]  retTag;
    logic [31:0] retData;
    logic        flush;
    logic [4:0]  lk0;
    logic [31:0] expD0;
    logic [5:0]  expT0;
    logic        expR0;
    logic [4:0]  lk1;
    logic [31:0] expD1;
    logic [5:0]  expT1;
    logic        expR1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic renEn, logic [4:0] renRd, logic [5:0] renTag,
                              logic retEn, logic [4:0] retRd, logic [5:0] retTag,
                              logic [31:0] retData, logic flush,
                              logic [4:0] lk0, logic [31:0] expD0, logic [5:0] expT0, logic expR0,
                              logic [4:0] lk1, logic [31:0] expD1, logic [5:0] expT1, logic expR1);
    vec_t v;
    v.name = name; v.renEn = renEn; v.renRd = renRd; v.renTag = renTag;
    v.retEn = retEn; v.retRd = retRd; v.retTag = retTag; v.retData = retData; v.flush = flush;
    v.lk0 = lk0; v.expD0 = expD0; v.expT0 = expT0; v.expR0 = expR0;
    v.lk1 = lk1; v.expD1 = expD1; v.expT1 = expT1; v.expR1 = expR1;
    return v;
  endfunction

  task automatic checkOutput(string name, int port, logic [31:0] expD, logic [5:0] expT, logic expR);
    checks++;
    if (o_lookup_data[port] !== expD || o_lookup_tag[port] !== expT || o_lookup_rdy[port] !== expR) begin
      errors++;
      $display("[TB] FAIL %s port%0d: got data=%h tag=%0d rdy=%b, expected data=%h tag=%0d rdy=%b",
               name, port, o_lookup_data[port], o_lookup_tag[port], o_lookup_rdy[port],
               expD, expT, expR);
    end
  endtask

  task automatic idleInputs();
    i_flush = 1'b0;
    i_dest_wr_en = 1'b0; i_dest_wr_rdest = '0; i_dest_wr_tag = '0; i_dest_wr_data = '0;
    i_tag_wr_en = 1'b0;  i_tag_wr_rdest = '0;  i_tag_wr_tag = '0;
  endtask

  task automatic applyStimulus(vec_t v);
    @(negedge clk);
    i_tag_wr_en = v.renEn;   i_tag_wr_rdest = v.renRd;   i_tag_wr_tag = v.renTag;
    i_dest_wr_en = v.retEn;  i_dest_wr_rdest = v.retRd;  i_dest_wr_tag = v.retTag;
    i_dest_wr_data = v.retData;
    i_flush = v.flush;
    i_lookup_rsrc[0] = v.lk0;
    i_lookup_rsrc[1] = v.lk1;
    @(posedge clk);
    #1;
    idleInputs();
    #1;
    checkOutput(v.name, 0, v.expD0, v.expT0, v.expR0);
    checkOutput(v.name, 1, v.expD1, v.expT1, v.expR1);
  endtask

  initial begin
    n_rst = 1'b0;
    idleInputs();
    i_lookup_rsrc[0] = 5'd3;
    i_lookup_rsrc[1] = 5'd0;

    // Reset state is visible while reset is held, before any clock edge matters.
    #12;
    checkOutput("reset_r3", 0, 32'h0, 6'd0, 1'b1);
    checkOutput("reset_r0", 1, 32'h0, 6'd0, 1'b1);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_r3", 0, 32'h0, 6'd0, 1'b1);

    //                name           renEn rd     tag    retEn rd     tag    data           flush lk0   d0             t0     r0    lk1   d1             t1     r1
    vecs.push_back(mk("rename_r5_t7",  1, 5'd5,  6'd7,  0, 5'd0,  6'd0,  32'h0,         0, 5'd5,  32'h0,         6'd7,  0, 5'd0,  32'h0,         6'd0,  1));
    vecs.push_back(mk("retire_r5_t7",  0, 5'd0,  6'd0,  1, 5'd5,  6'd7,  32'hDEADBEEF,  0, 5'd5,  32'hDEADBEEF,  6'd7,  1, 5'd5,  32'hDEADBEEF,  6'd7,  1));
    vecs.push_back(mk("rename2_r5_t7", 1, 5'd5,  6'd7,  0, 5'd0,  6'd0,  32'h0,         0, 5'd5,  32'hDEADBEEF,  6'd7,  0, 5'd0,  32'h0,         6'd0,  1));
    vecs.push_back(mk("rename_r5_t9",  1, 5'd5,  6'd9,  0, 5'd0,  6'd0,  32'h0,         0, 5'd5,  32'hDEADBEEF,  6'd9,  0, 5'd3,  32'h0,         6'd0,  1));
    vecs.push_back(mk("stale_retire",  0, 5'd0,  6'd0,  1, 5'd5,  6'd7,  32'h11,        0, 5'd5,  32'h11,        6'd9,  0, 5'd5,  32'h11,        6'd9,  0));
    vecs.push_back(mk("ret_ren_r8",    1, 5'd8,  6'd4,  1, 5'd8,  6'd2,  32'h55,        0, 5'd8,  32'h55,        6'd4,  0, 5'd5,  32'h11,        6'd9,  0));
    vecs.push_back(mk("rename_r1",     1, 5'd1,  6'd10, 0, 5'd0,  6'd0,  32'h0,         0, 5'd1,  32'h0,         6'd10, 0, 5'd8,  32'h55,        6'd4,  0));
    vecs.push_back(mk("rename_r2",     1, 5'd2,  6'd11, 0, 5'd0,  6'd0,  32'h0,         0, 5'd2,  32'h0,         6'd11, 0, 5'd1,  32'h0,         6'd10, 0));
    vecs.push_back(mk("rename_r3",     1, 5'd3,  6'd12, 0, 5'd0,  6'd0,  32'h0,         0, 5'd3,  32'h0,         6'd12, 0, 5'd2,  32'h0,         6'd11, 0));
    vecs.push_back(mk("flush_ren_r3",  1, 5'd3,  6'd13, 0, 5'd0,  6'd0,  32'h0,         1, 5'd3,  32'h0,         6'd12, 1, 5'd1,  32'h0,         6'd10, 1));
    vecs.push_back(mk("after_flush",   0, 5'd0,  6'd0,  0, 5'd0,  6'd0,  32'h0,         0, 5'd2,  32'h0,         6'd11, 1, 5'd5,  32'h11,        6'd9,  1));
    vecs.push_back(mk("write_r0",      1, 5'd0,  6'd3,  1, 5'd0,  6'd0,  32'hFF,        0, 5'd0,  32'h0,         6'd0,  1, 5'd0,  32'h0,         6'd0,  1));
    vecs.push_back(mk("retire_r9",     0, 5'd0,  6'd0,  1, 5'd9,  6'd0,  32'h77,        0, 5'd9,  32'h77,        6'd0,  1, 5'd8,  32'h55,        6'd4,  1));
    vecs.push_back(mk("flush_retire",  0, 5'd0,  6'd0,  1, 5'd8,  6'd9,  32'h66,        1, 5'd8,  32'h66,        6'd4,  1, 5'd9,  32'h77,        6'd0,  1));
    vecs.push_back(mk("rename_r6_t20", 1, 5'd6,  6'd20, 0, 5'd0,  6'd0,  32'h0,         0, 5'd6,  32'h0,         6'd20, 0, 5'd5,  32'h11,        6'd9,  1));

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Same-cycle retire of r6 while looking it up.
    @(negedge clk);
    i_dest_wr_en = 1'b1; i_dest_wr_rdest = 5'd6; i_dest_wr_tag = 6'd20; i_dest_wr_data = 32'hA5;
    i_lookup_rsrc[0] = 5'd6; i_lookup_rsrc[1] = 5'd6;
    #1;
`ifdef REGMAP_RETIRE_BYPASS_EN
    checkOutput("bypass_r6", 0, 32'hA5, 6'd20, 1'b1);
    checkOutput("bypass_r6", 1, 32'hA5, 6'd20, 1'b1);
`else
    checkOutput("no_bypass_r6", 0, 32'h0, 6'd20, 1'b0);
    checkOutput("no_bypass_r6", 1, 32'h0, 6'd20, 1'b0);
`endif
    @(posedge clk); #1;
    idleInputs(); #1;
    checkOutput("retired_r6", 0, 32'hA5, 6'd20, 1'b1);

    // A rename must not show on lookups in its own cycle.
    @(negedge clk);
    i_tag_wr_en = 1'b1; i_tag_wr_rdest = 5'd7; i_tag_wr_tag = 6'd5;
    i_lookup_rsrc[0] = 5'd7;
    #1;
    checkOutput("pre_rename_r7", 0, 32'h0, 6'd0, 1'b1);
    @(posedge clk); #1;
    idleInputs(); #1;
    checkOutput("post_rename_r7", 0, 32'h0, 6'd5, 1'b0);

    // Asynchronous reset mid-cycle with a rename pending.
    @(negedge clk);
    i_tag_wr_en = 1'b1; i_tag_wr_rdest = 5'd10; i_tag_wr_tag = 6'd1;
    i_lookup_rsrc[0] = 5'd5; i_lookup_rsrc[1] = 5'd7;
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("async_reset_r5", 0, 32'h0, 6'd0, 1'b1);
    checkOutput("async_reset_r7", 1, 32'h0, 6'd0, 1'b1);
    @(posedge clk); #1;
    idleInputs();
    @(negedge clk);
    n_rst = 1'b1;
    i_lookup_rsrc[0] = 5'd10; i_lookup_rsrc[1] = 5'd6;
    @(posedge clk); #1;
    checkOutput("reset_drop_r10", 0, 32'h0, 6'd0, 1'b1);
    checkOutput("reset_clear_r6", 1, 32'h0, 6'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_map.md
REGISTER_MAP -- requirements
Module: register_map

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the register data width.
REQ-002 SHALL have parameter ROB_DEPTH, default 64, the ROB entry count; localparam TAG_WIDTH = $clog2(ROB_DEPTH).
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5, the architectural register index width (2**REG_ADDR_WIDTH registers).
REQ-004 SHALL have port clk  input  1  the single clock, rising edge.
REQ-005 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-006 SHALL have port i_flush  input  1  branch-taken flush from the ROB.
REQ-007 SHALL have port i_dest_wr_en  input  1  retire write enable.
REQ-008 SHALL have port i_dest_wr_rdest  input  REG_ADDR_WIDTH  retiring destination register.
REQ-009 SHALL have port i_dest_wr_tag  input  TAG_WIDTH  ROB tag of the retiring entry.
REQ-010 SHALL have port i_dest_wr_data  input  DATA_WIDTH  retiring result.
REQ-011 SHALL have port i_tag_wr_en  input  1  rename enable for a newly dispatched instruction.
REQ-012 SHALL have port i_tag_wr_rdest  input  REG_ADDR_WIDTH  renamed destination register.
REQ-013 SHALL have port i_tag_wr_tag  input  TAG_WIDTH  ROB tag allocated to that instruction.
REQ-014 SHALL have ports i_lookup_rsrc[0:1]  input  2 x REG_ADDR_WIDTH  source register indices.
REQ-015 SHALL have ports o_lookup_data[0:1]  output  2 x DATA_WIDTH  committed source data.
REQ-016 SHALL have ports o_lookup_tag[0:1]  output  2 x TAG_WIDTH  producing ROB tag.
REQ-017 SHALL have ports o_lookup_rdy[0:1]  output  2 x 1  1 = data is committed and valid.

Function
REQ-018 SHALL hold one entry per architectural register: data, tag and rdy, as flops.
REQ-019 SHALL, on rising clk with i_tag_wr_en=1 and i_tag_wr_rdest!=0, set that entry's tag=i_tag_wr_tag and rdy=0.
REQ-020 SHALL, on rising clk with i_dest_wr_en=1 and i_dest_wr_rdest!=0, write data=i_dest_wr_data.
REQ-021 SHALL, on retire, set rdy=1 only if the stored tag equals i_dest_wr_tag; on mismatch (a younger rename exists) rdy and tag are unchanged.
REQ-022 SHALL, on rename and retire of the same register in one cycle, apply the retire data write and leave the rename's tag and rdy=0 in place.
REQ-023 SHALL, on i_flush=1, set rdy=1 on every entry and leave tags unchanged; i_tag_wr_en is ignored that cycle.
REQ-024 SHALL, on i_flush and a retire in the same cycle, still apply the retire data write.
REQ-025 SHALL hardwire register 0: writes are ignored, and lookup returns data=0, tag=0, rdy=1.
REQ-026 SHALL drive the lookup outputs combinationally (zero latency) from the indexed entry.
REQ-027 SHALL NOT reflect a same-cycle rename on the lookup outputs, so sources see the pre-rename mapping.
REQ-028 SHALL serve both lookup ports independently; equal indices on both ports return identical values.

Reset
REQ-029 SHALL, while n_rst=0 and regardless of clk, force every entry to data=0, tag=0, rdy=1.
REQ-030 SHALL drive lookup outputs of data=0, tag=0, rdy=1 for every index during and after reset until the first write.
REQ-031 SHALL, on reset asserted mid-operation, discard all pending renames; no partial state survives.

Configuration
REQ-032 SHALL support macro REGMAP_RETIRE_BYPASS_EN.
REQ-033 SHALL, with REGMAP_RETIRE_BYPASS_EN defined, drive a same-cycle retire to lookup when the retire writes the indexed register and its tag matches the stored tag: data=i_dest_wr_data, rdy=1.
REQ-034 SHALL, without REGMAP_RETIRE_BYPASS_EN, drive lookup from stored state only, so a retire becomes visible the cycle after it.

Verification
REQ-035 SHALL cover reset then lookup of r3 and r0 -> data=0, tag=0, rdy=1 on both.
REQ-036 SHALL cover rename r5 to tag 7, then retire r5 with tag 7 and data 0xDEADBEEF -> next-cycle lookup r5 returns 0xDEADBEEF, tag=7, rdy=1.
REQ-037 SHALL cover rename r5 to tag 7, rename r5 to tag 9, retire r5 with tag 7 and data 0x11 -> lookup r5 returns data=0x11, tag=9, rdy=0.
REQ-038 SHALL cover retire and rename of r8 in the same cycle (retire tag 2, data 0x55; rename tag 4) -> lookup r8 returns data=0x55, tag=4, rdy=0.
REQ-039 SHALL cover renames r1 and r2 followed by i_flush=1 together with a rename of r3 -> r1, r2 and r3 all rdy=1 and r3's tag unchanged.
REQ-040 SHALL cover retire r6 with a matching tag and data 0xA5 while looking up r6 in the same cycle -> rdy=1, data=0xA5 with REGMAP_RETIRE_BYPASS_EN, and rdy=0 (prior data) without it.
